// File: rtl/axis_line_framer_if.sv
// -----------------------------------------------------------------------------
// axis_if : AXI-Stream bundle used on both sides of axis_line_framer.
//
// Signals
//   tvalid  beat valid (driven by master)
//   tready  sink can accept (driven by slave)
//   tdata   DATA_WIDTH-bit pixel
//   tkeep   byte enables
//   tlast   end marker (frame end upstream, line end downstream)
//   tuser   start-of-frame marker
// Modports
//   master : drives tvalid/tdata/tkeep/tlast/tuser, samples tready
//   slave  : samples tvalid/tdata/tkeep/tlast/tuser, drives tready
// -----------------------------------------------------------------------------
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;

  modport master (output tvalid, output tdata, output tkeep, output tlast,
                  output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast,
                  input tuser, output tready);
endinterface

// File: rtl/axis_line_framer.sv
// -----------------------------------------------------------------------------
// axis_line_framer
//
// Buffers an upsampled pixel stream in a small FIFO, tracks destination x/y
// coordinates and re-frames the stream: tlast on the last pixel of every
// destination line, tuser on the first pixel of every frame. Reports
// per-frame completion and (optionally) frame-length errors.
//
// Optional feature: define LINE_FRAMER_LEN_CHECK_EN to compare upstream
// s_axis.tlast against the counted frame end (early tlast truncates the
// frame; any mismatch sets the sticky err_len). Without it, upstream tlast
// is ignored and err_len is tied low.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   s_axis     AXI-Stream slave (pixel in, tlast = upstream end of frame)
//   m_axis     AXI-Stream master (pixel out, tlast = end of line,
//              tuser = start of frame, tkeep all ones while valid)
//   frame_done one-cycle pulse after a frame has fully left the FIFO
//   err_len    sticky frame-length mismatch flag
//   busy       FSM not idle
// -----------------------------------------------------------------------------
module axis_line_framer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int DST_IMG_WIDTH   = 4096,
  parameter int DST_IMG_HEIGHT  = 2160,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic    clk,
  input  logic    rst,
  axis_if.slave   s_axis,
  axis_if.master  m_axis,
  output logic    frame_done,
  output logic    err_len,
  output logic    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(DST_IMG_WIDTH);
  // A single-line frame still needs a 1-bit y counter to keep widths legal.
  localparam int YW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int KW = AXIS_DATA_WIDTH / 8;

  localparam logic [XW-1:0] X_LAST   = XW'(DST_IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(DST_IMG_HEIGHT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       sof;
    logic                       eol;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  entry_t          push_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  state_t          state;
  state_t          state_next;
  logic            push;
  logic            pop;
  logic            at_end;
  logic            last_px;
  logic            drain_done;
  logic            unused_inputs;

  // Upstream tkeep/tuser carry no information for a one-pixel-per-beat stream.
  assign unused_inputs = ^{s_axis.tkeep, s_axis.tuser, s_axis.tlast};

  // Input is refused while draining and whenever the FIFO is full, even if a
  // pop happens in the same cycle, so tready never depends on m_axis.tready.
  assign s_axis.tready = (state != DRAIN) && (count != CNT_FULL);
  assign push          = s_axis.tvalid & s_axis.tready;
  assign pop           = m_axis.tvalid & m_axis.tready;

  assign at_end = (x == X_LAST) && (y == Y_LAST);

`ifdef LINE_FRAMER_LEN_CHECK_EN
  // An early upstream tlast truncates the frame at this beat.
  assign last_px = at_end | s_axis.tlast;

  // Sticky length error: upstream tlast disagrees with the counted frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len <= 1'b0;
    end else if (push && (s_axis.tlast != at_end)) begin
      err_len <= 1'b1;
    end else begin
      err_len <= err_len;
    end
  end
`else
  assign last_px = at_end;
  assign err_len = 1'b0;
`endif

  // Entry flags are derived from the coordinates of the beat being pushed.
  always_comb begin
    push_entry      = '0;
    push_entry.data = s_axis.tdata;
    push_entry.sof  = (x == {XW{1'b0}}) && (y == {YW{1'b0}});
    push_entry.eol  = (x == X_LAST) || last_px;
  end

  // FIFO storage; contents need no reset because count gates the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Destination coordinates advance on accepted input beats only.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= {XW{1'b0}};
      y <= {YW{1'b0}};
    end else if (push) begin
      if (last_px) begin
        x <= {XW{1'b0}};
        y <= {YW{1'b0}};
      end else if (x == X_LAST) begin
        x <= {XW{1'b0}};
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
        y <= y;
      end
    end else begin
      x <= x;
      y <= y;
    end
  end

  // In DRAIN only the current frame is buffered, so the last entry leaving
  // with eol set is that frame's final beat.
  assign drain_done = pop && head.eol && (count == CW'(1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) begin
          state_next = last_px ? DRAIN : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (push && last_px) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion pulse appears in the first IDLE cycle after draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && (state_next == IDLE);
    end
  end

  assign busy = (state != IDLE);

  // Output side reads the FIFO head; everything is forced to 0 when empty.
  assign head          = mem[rd_ptr];
  assign m_axis.tvalid = (count != {CW{1'b0}});
  assign m_axis.tdata  = m_axis.tvalid ? head.data : {AXIS_DATA_WIDTH{1'b0}};
  assign m_axis.tkeep  = m_axis.tvalid ? {KW{1'b1}} : {KW{1'b0}};
  assign m_axis.tlast  = m_axis.tvalid & head.eol;
  assign m_axis.tuser  = m_axis.tvalid & head.sof;

endmodule

// File: tb/tb_axis_line_framer.sv
// -----------------------------------------------------------------------------
// tb_axis_line_framer : directed, table-driven bench for axis_line_framer
// configured with a 4x2 destination frame and a 4-entry FIFO.
// -----------------------------------------------------------------------------
module tb_axis_line_framer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 32;

  logic clk;
  logic rst;
  logic frame_done;
  logic err_len;
  logic busy;

  int n_checks;
  int n_fail;

  axis_if #(.DATA_WIDTH(DW)) s_if ();
  axis_if #(.DATA_WIDTH(DW)) m_if ();

  axis_line_framer #(
    .AXIS_DATA_WIDTH (DW),
    .DST_IMG_WIDTH   (W),
    .DST_IMG_HEIGHT  (H),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .frame_done (frame_done),
    .err_len    (err_len),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic        e_sready;
    logic        e_mvalid;
    logic [31:0] e_mdata;
    logic        e_mlast;
    logic        e_muser;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feed n beats (data base+i), frame length flen seen at the output, an
  // extra upstream tlast at in-frame position early, output stalled for the
  // first 'stall' cycles. Checks output data/framing, frame_done timing,
  // hold-stability under stall and the full-FIFO refusal.
  task automatic run_frame(input int base, input int n, input int flen,
                           input int early, input int stall);
    int sent;
    int got;
    int cyc;
    int done_at;
    int stalls;
    int p;
    int q;
    logic [31:0] held;
    bit held_ok;
    sent = 0; got = 0; cyc = 0; done_at = -10; stalls = 0; held_ok = 0; held = 32'd0;
    while ((got < n || cyc <= done_at + 1) && cyc < 400) begin
      @(negedge clk);
      m_if.tready = (cyc >= stall);
      s_if.tvalid = (sent < n);
      s_if.tdata  = base + sent;
      p = sent % flen;
      s_if.tlast  = (sent < n) && ((p == flen - 1) || (p == early));
      #1;
      chk("frame_done", {31'd0, frame_done}, {31'd0, (cyc == done_at)});
      if (stall >= 5 && cyc == stall) begin
        chk("accepted_while_stalled", sent, 4);
        chk("full_pop_sready", {31'd0, s_if.tready}, 32'd0);
      end
      if (stall >= 5 && cyc == stall + 1) begin
        chk("refill_sready", {31'd0, s_if.tready}, 32'd1);
      end
      if (!m_if.tready && m_if.tvalid) begin
        if (held_ok) chk("hold_stable", m_if.tdata, held);
        held = m_if.tdata;
        held_ok = 1;
      end
      if (s_if.tvalid && !s_if.tready && m_if.tready) stalls++;
      if (s_if.tvalid && s_if.tready) sent++;
      if (m_if.tvalid && m_if.tready) begin
        q = got % flen;
        chk("out_data", m_if.tdata, base + got);
        chk("out_tlast", {31'd0, m_if.tlast}, {31'd0, ((q % W == W - 1) || (q == flen - 1))});
        chk("out_tuser", {31'd0, m_if.tuser}, {31'd0, (q == 0)});
        if (q == flen - 1) done_at = cyc + 1;
        got++;
      end
      cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (cyc >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_frame_timeout: got %0d beats expected %0d", got, n);
    end
    if (n > flen && stall == 0) chk("drain_stalls", stalls, n / flen - 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = 32'd0; s_if.tlast = 1'b0;
    s_if.tkeep = 4'h0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;

    //           v     d      l     mr    srdy  mval  mdata  mlast muser done  busy
    vecs[0]  = '{1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'd6, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_tkeep", {28'd0, m_if.tkeep}, 32'd0);
    chk("reset_err_len", {31'd0, err_len}, 32'd0);

    // Basic frame, one table row per cycle.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      s_if.tvalid = vecs[i].v;
      s_if.tdata  = vecs[i].d;
      s_if.tlast  = vecs[i].l;
      m_if.tready = vecs[i].mr;
      #1;
      chk("tbl_sready", {31'd0, s_if.tready}, {31'd0, vecs[i].e_sready});
      chk("tbl_mvalid", {31'd0, m_if.tvalid}, {31'd0, vecs[i].e_mvalid});
      chk("tbl_mdata",  m_if.tdata, vecs[i].e_mdata);
      chk("tbl_mlast",  {31'd0, m_if.tlast}, {31'd0, vecs[i].e_mlast});
      chk("tbl_muser",  {31'd0, m_if.tuser}, {31'd0, vecs[i].e_muser});
      chk("tbl_tkeep",  {28'd0, m_if.tkeep}, vecs[i].e_mvalid ? 32'hF : 32'h0);
      chk("tbl_done",   {31'd0, frame_done}, {31'd0, vecs[i].e_done});
      chk("tbl_busy",   {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk("tbl_err",    {31'd0, err_len}, 32'd0);
    end
    s_if.tvalid = 1'b0;

    // Back-pressure for 10 cycles, full FIFO with simultaneous pop.
    run_frame(32'h100, 8, 8, -1, 10);
    // Two back-to-back frames; input stalls once in DRAIN.
    run_frame(32'h200, 16, 8, -1, 0);

`ifdef LINE_FRAMER_LEN_CHECK_EN
    // Early tlast on beat 5 truncates the frame and sets err_len.
    run_frame(32'h400, 6, 6, 5, 0);
    chk("err_len_set", {31'd0, err_len}, 32'd1);
    run_frame(32'h500, 8, 8, -1, 0);
    chk("err_len_sticky", {31'd0, err_len}, 32'd1);
`else
    // Upstream tlast is ignored: early tlast does not shorten the frame.
    run_frame(32'h400, 8, 8, 5, 0);
    chk("err_len_tied", {31'd0, err_len}, 32'd0);
`endif

    // Mid-frame reset with three beats buffered.
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h600 + i;
      s_if.tlast  = 1'b0;
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    #1;
    chk("pre_reset_mvalid", {31'd0, m_if.tvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_sready", {31'd0, s_if.tready}, 32'd1);
    chk("rst_mvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_mdata",  m_if.tdata, 32'd0);
    chk("rst_mlast",  {31'd0, m_if.tlast}, 32'd0);
    chk("rst_muser",  {31'd0, m_if.tuser}, 32'd0);
    chk("rst_tkeep",  {28'd0, m_if.tkeep}, 32'd0);
    chk("rst_done",   {31'd0, frame_done}, 32'd0);
    chk("rst_err",    {31'd0, err_len}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);

    // Next frame after reset starts at sof.
    run_frame(32'h700, 8, 8, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
